// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with memory-stall hold, flush
// (bubble insertion), one-shot HALT/dump sequencing and a saturating
// counter of memory-stall cycles.
module ex_mem_reg #(
  parameter int DW = 16,
  parameter int RW = 3,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_ALUOut,
  input  logic [DW-1:0] ex_WriteData,
  input  logic          ex_MemToReg,
  input  logic          ex_MemWrite,
  input  logic          ex_Dump,
  input  logic          ex_RegWrite,
  input  logic [RW-1:0] ex_WriteReg,
  input  logic          flush,
  input  logic          mem_stall,
  output logic [DW-1:0] ALUOut,
  output logic [DW-1:0] WriteData,
  output logic          Enable,
  output logic          MemToReg,
  output logic          MemWrite,
  output logic          Dump,
  output logic          RegWrite,
  output logic [RW-1:0] WriteReg,
  output logic          valid,
  output logic          ex_stall,
  output logic          halted,
  output logic [CW-1:0] stall_count
);

  // IDLE: no entry; ACCESS: entry on its first cycle; WAIT: entry held by
  // mem_stall; HALT: terminal until reset.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] aluout_q, aluout_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          memtoreg_q, memtoreg_d;
  logic          memwrite_q, memwrite_d;
  logic          dump_q, dump_d;
  logic          regwrite_q, regwrite_d;
  logic [RW-1:0] writereg_q, writereg_d;
  logic          pend_flush_q, pend_flush_d;
  logic [CW-1:0] stall_count_q, stall_count_d;
  logic          hold;

  // An issued memory access is frozen while the memory stage is busy.
  assign hold = ((state_q == S_ACCESS) || (state_q == S_WAIT)) && mem_stall;

  // Next-state and next-entry selection: halt, hold, dump retire, capture or bubble.
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    aluout_d      = aluout_q;
    wdata_d       = wdata_q;
    memtoreg_d    = memtoreg_q;
    memwrite_d    = memwrite_q;
    dump_d        = dump_q;
    regwrite_d    = regwrite_q;
    writereg_d    = writereg_q;
    pend_flush_d  = pend_flush_q;
    stall_count_d = stall_count_q;

    if (state_q == S_HALT) begin
      state_d = S_HALT;
    end else if (hold) begin
      state_d = S_WAIT;
      if (stall_count_q != {CW{1'b1}}) begin
        stall_count_d = stall_count_q + 1'b1;
      end
      // The held access is already issued, so a flush is deferred to the
      // next instruction from execute instead.
      if (flush) begin
        pend_flush_d = 1'b1;
      end
    end else begin
      pend_flush_d = 1'b0;
      valid_d      = 1'b0;
      aluout_d     = '0;
      wdata_d      = '0;
      memtoreg_d   = 1'b0;
      memwrite_d   = 1'b0;
      dump_d       = 1'b0;
      regwrite_d   = 1'b0;
      writereg_d   = '0;
      if (valid_q && dump_q) begin
        // The dump request has just been presented; freeze the pipeline.
        state_d = S_HALT;
      end else if (ex_valid && !flush && !pend_flush_q) begin
        state_d    = S_ACCESS;
        valid_d    = 1'b1;
        aluout_d   = ex_ALUOut;
        wdata_d    = ex_WriteData;
        memtoreg_d = ex_MemToReg;
        memwrite_d = ex_MemWrite;
        dump_d     = ex_Dump;
        regwrite_d = ex_RegWrite;
        writereg_d = ex_WriteReg;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // Pipeline register, FSM state and stall counter with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      valid_q       <= 1'b0;
      aluout_q      <= '0;
      wdata_q       <= '0;
      memtoreg_q    <= 1'b0;
      memwrite_q    <= 1'b0;
      dump_q        <= 1'b0;
      regwrite_q    <= 1'b0;
      writereg_q    <= '0;
      pend_flush_q  <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      aluout_q      <= aluout_d;
      wdata_q       <= wdata_d;
      memtoreg_q    <= memtoreg_d;
      memwrite_q    <= memwrite_d;
      dump_q        <= dump_d;
      regwrite_q    <= regwrite_d;
      writereg_q    <= writereg_d;
      pend_flush_q  <= pend_flush_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Control outputs are gated by valid; Dump fires only on the releasing cycle.
  always_comb begin
    ALUOut      = aluout_q;
    WriteData   = wdata_q;
    valid       = valid_q;
    MemToReg    = valid_q & memtoreg_q;
    MemWrite    = valid_q & memwrite_q;
    Enable      = valid_q & (memtoreg_q | memwrite_q);
    RegWrite    = valid_q & regwrite_q;
    WriteReg    = writereg_q;
    Dump        = valid_q & dump_q & ~hold;
    halted      = (state_q == S_HALT);
    ex_stall    = hold | (state_q == S_HALT);
    stall_count = stall_count_q;
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: randomized and directed stimulus for ex_mem_reg, checked
// every cycle against an entry-level behavioural model, plus literal pins.
module tb_ex_mem_reg;
  localparam int DW = 16;
  localparam int RW = 3;
  localparam int CW = 16;
  localparam int CMAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          ex_valid = 0, ex_MemToReg = 0, ex_MemWrite = 0, ex_Dump = 0, ex_RegWrite = 0;
  logic [DW-1:0] ex_ALUOut = '0, ex_WriteData = '0;
  logic [RW-1:0] ex_WriteReg = '0;
  logic          flush = 0, mem_stall = 0;
  logic [DW-1:0] ALUOut, WriteData;
  logic          Enable, MemToReg, MemWrite, Dump, RegWrite, valid, ex_stall, halted;
  logic [RW-1:0] WriteReg;
  logic [CW-1:0] stall_count;

  ex_mem_reg #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ALUOut(ex_ALUOut),
    .ex_WriteData(ex_WriteData), .ex_MemToReg(ex_MemToReg), .ex_MemWrite(ex_MemWrite),
    .ex_Dump(ex_Dump), .ex_RegWrite(ex_RegWrite), .ex_WriteReg(ex_WriteReg),
    .flush(flush), .mem_stall(mem_stall), .ALUOut(ALUOut), .WriteData(WriteData),
    .Enable(Enable), .MemToReg(MemToReg), .MemWrite(MemWrite), .Dump(Dump),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .valid(valid), .ex_stall(ex_stall),
    .halted(halted), .stall_count(stall_count)
  );

  int tests = 0;
  int fails = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One pipeline slot: either empty or holding an instruction record.
  typedef struct {
    bit          v;
    bit [DW-1:0] alu, wd;
    bit          ld, st, dmp, rw;
    bit [RW-1:0] wr;
  } entry_t;

  entry_t m_e;
  bit     m_pend, m_halted;
  int     m_count;

  initial begin
    m_e = '{default: 0};
    m_pend = 0; m_halted = 0; m_count = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_e = '{default: 0};
      m_pend = 0; m_halted = 0; m_count = 0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (m_e.v && mem_stall) begin
      if (m_count < CMAX) m_count = m_count + 1;
      if (flush) m_pend = 1;
    end else begin
      if (m_e.v && m_e.dmp) begin
        m_halted = 1;
        m_e = '{default: 0};
      end else if (ex_valid && !flush && !m_pend) begin
        m_e = '{v: 1, alu: ex_ALUOut, wd: ex_WriteData, ld: ex_MemToReg, st: ex_MemWrite,
                dmp: ex_Dump, rw: ex_RegWrite, wr: ex_WriteReg};
      end else begin
        m_e = '{default: 0};
      end
      m_pend = 0;
    end
  end

  // Compare every cycle once reset has been applied.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("valid", valid, m_e.v);
      chk("ALUOut", ALUOut, m_e.alu);
      chk("WriteData", WriteData, m_e.wd);
      chk("MemToReg", MemToReg, m_e.v & m_e.ld);
      chk("MemWrite", MemWrite, m_e.v & m_e.st);
      chk("Enable", Enable, m_e.v & (m_e.ld | m_e.st));
      chk("RegWrite", RegWrite, m_e.v & m_e.rw);
      chk("WriteReg", WriteReg, m_e.wr);
      chk("Dump", Dump, m_e.v & m_e.dmp & !mem_stall);
      chk("halted", halted, m_halted);
      chk("ex_stall", ex_stall, m_halted | (m_e.v & mem_stall));
      chk("stall_count", stall_count, m_count);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input bit v, input bit [DW-1:0] alu, input bit [DW-1:0] wd,
                        input bit ld, input bit st, input bit dmp, input bit rw,
                        input bit [RW-1:0] wr);
    ex_valid = v; ex_ALUOut = alu; ex_WriteData = wd; ex_MemToReg = ld;
    ex_MemWrite = st; ex_Dump = dmp; ex_RegWrite = rw; ex_WriteReg = wr;
  endtask

  task automatic idle_ex();
    set_ex(0, '0, '0, 0, 0, 0, 0, '0);
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; mem_stall = 0; idle_ex();
    tick();
    rst = 0;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    cmp_en = 1;
    at_neg();
    chk("rst_valid", valid, 0);
    chk("rst_ALUOut", ALUOut, 0);
    chk("rst_count", stall_count, 0);
    chk("rst_ex_stall", ex_stall, 0);

    // Store captured, presented next cycle.
    set_ex(1, 16'h1234, 16'hBEEF, 0, 1, 0, 0, 3'd0);
    tick(); idle_ex();
    at_neg();
    chk("st_Enable", Enable, 1);
    chk("st_MemWrite", MemWrite, 1);
    chk("st_ALUOut", ALUOut, 16'h1234);
    chk("st_WriteData", WriteData, 16'hBEEF);
    chk("st_valid", valid, 1);
    chk("st_ex_stall", ex_stall, 0);

    // Load held by 3 stall cycles; next instruction waits behind it.
    do_reset();
    set_ex(1, 16'h0040, 16'h0000, 1, 0, 0, 1, 3'd2);
    tick();
    set_ex(1, 16'h0050, 16'h0007, 0, 0, 0, 1, 3'd5);
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("ld_hold_ex_stall", ex_stall, 1);
      chk("ld_hold_ALUOut", ALUOut, 16'h0040);
      chk("ld_hold_MemToReg", MemToReg, 1);
      tick();
    end
    mem_stall = 0;
    at_neg();
    chk("ld_count3", stall_count, 3);
    chk("ld_release_ALUOut", ALUOut, 16'h0040);
    chk("ld_release_ex_stall", ex_stall, 0);
    tick(); idle_ex();
    at_neg();
    chk("next_ALUOut", ALUOut, 16'h0050);
    chk("next_WriteReg", WriteReg, 3'd5);

    // Flush with ex_valid and no hold yields a bubble.
    set_ex(1, 16'h0AAA, 16'h0BBB, 1, 0, 0, 1, 3'd1);
    flush = 1;
    tick(); flush = 0; idle_ex();
    at_neg();
    chk("fl_valid", valid, 0);
    chk("fl_Enable", Enable, 0);
    chk("fl_RegWrite", RegWrite, 0);

    // Flush during WAIT: held entry survives, next instruction squashed.
    set_ex(1, 16'h0C00, 16'h0C01, 0, 1, 0, 0, 3'd0);
    tick();
    set_ex(1, 16'h0D00, 16'h0D01, 1, 0, 0, 1, 3'd4);
    mem_stall = 1; flush = 1;
    tick(); flush = 0;
    tick(); mem_stall = 0;
    at_neg();
    chk("wfl_held_ALUOut", ALUOut, 16'h0C00);
    chk("wfl_held_Enable", Enable, 1);
    tick();
    at_neg();
    chk("wfl_bubble_valid", valid, 0);
    tick(); idle_ex();
    at_neg();
    chk("wfl_after_valid", valid, 1);
    chk("wfl_after_ALUOut", ALUOut, 16'h0D00);

    // Reset during WAIT with stall_count=5; mem_stall kept high in IDLE.
    do_reset();
    set_ex(1, 16'h0100, 16'h0000, 1, 0, 0, 1, 3'd3);
    tick(); idle_ex();
    mem_stall = 1;
    repeat (5) tick();
    at_neg();
    chk("pre_rst_count5", stall_count, 5);
    rst = 1;
    tick(); rst = 0;
    at_neg();
    chk("mrst_valid", valid, 0);
    chk("mrst_ALUOut", ALUOut, 0);
    chk("mrst_count", stall_count, 0);
    chk("mrst_ex_stall", ex_stall, 0);
    tick();
    at_neg();
    chk("idle_stall_ignored", stall_count, 0);
    mem_stall = 0;

    // Randomized traffic (no HALT so the run keeps flowing).
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      set_ex($urandom_range(0, 3) != 0, DW'($urandom), DW'($urandom),
             1'($urandom), 1'($urandom), 0, 1'($urandom), RW'($urandom));
      flush = ($urandom_range(0, 9) == 0);
      mem_stall = ($urandom_range(0, 9) < 3);
      tick();
    end
    flush = 0; mem_stall = 0; idle_ex();

    // Saturation: long stall on one load.
    do_reset();
    set_ex(1, 16'h0200, 16'h0000, 1, 0, 0, 1, 3'd1);
    tick(); idle_ex();
    mem_stall = 1;
    repeat (70000) tick();
    at_neg();
    chk("sat_count", stall_count, 16'hFFFF);
    chk("sat_ALUOut", ALUOut, 16'h0200);
    mem_stall = 0;

    // HALT: dump entry stalled 2 cycles, Dump on release, then frozen.
    do_reset();
    set_ex(1, 16'h0300, 16'h0000, 0, 0, 1, 0, 3'd0);
    tick(); idle_ex();
    mem_stall = 1;
    at_neg();
    chk("dump_held_low", Dump, 0);
    repeat (2) tick();
    mem_stall = 0;
    at_neg();
    chk("dump_pulse", Dump, 1);
    tick();
    at_neg();
    chk("dump_gone", Dump, 0);
    chk("halt_halted", halted, 1);
    chk("halt_ex_stall", ex_stall, 1);
    chk("halt_valid", valid, 0);
    for (int i = 0; i < 10; i++) begin
      set_ex(1, DW'($urandom), DW'($urandom), 0, 1, 0, 1, RW'($urandom));
      mem_stall = 1'($urandom);
      tick();
      at_neg();
      chk("halt_no_Enable", Enable, 0);
    end
    idle_ex(); mem_stall = 0;
    rst = 1;
    tick(); rst = 0;
    at_neg();
    chk("unhalt_halted", halted, 0);

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
